// File: rtl/fc_ctrl_pkg.sv
// Shared types for the pipeline flow controller: FSM state encoding and the
// bundle of per-cycle control strobes that the controller drives.
package fc_ctrl_pkg;

    typedef enum logic [1:0] {
        FC_RUN    = 2'd0,
        FC_IWAIT  = 2'd1,
        FC_SQUASH = 2'd2,
        FC_DSTALL = 2'd3
    } fc_state_e;

    // Control strobes produced each cycle, before reset gating.
    typedef struct packed {
        logic valid;
        logic flush_id;
        logic flush_ex;
        logic bk_if;
        logic bk_id;
        logic bk_ex;
        logic bk_mem;
        logic redirect;
    } fc_ctl_t;

    // Freeze every stage on top of whatever else is being driven.
    function automatic fc_ctl_t fc_freeze(input fc_ctl_t c);
        fc_ctl_t r;
        r        = c;
        r.bk_if  = 1'b1;
        r.bk_id  = 1'b1;
        r.bk_ex  = 1'b1;
        r.bk_mem = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fc_sat_cnt.sv
// Width-parameterized up-counter that sticks at all-ones instead of wrapping.
module fc_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: hold unless enabled and not yet saturated.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so all registers update together at the edge.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fc_ctrl.sv
// Pipeline flow controller around the ID stage: arbitrates Dcache stall,
// redirects (EX branch over ID jump), load-use and Icache latency; drives the
// stage keep/flush strobes, the Icache valid qualifier and the PC redirect.
module fc_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Icache_ready_i,
    input  logic             Dcache_stall_i,
    input  logic             dhnf_load_use_i,
    input  logic             id_jump_flag_i,
    input  logic [PC_W-1:0]  id_jump_pc_i,
    input  logic             ex_btype_taken_i,
    input  logic [PC_W-1:0]  ex_btype_jump_pc_i,
    output logic             fc_Icache_data_valid_o,
    output logic             fc_flush_id_o,
    output logic             fc_flush_ex_o,
    output logic             fc_bk_if_o,
    output logic             fc_bk_id_o,
    output logic             fc_bk_ex_o,
    output logic             fc_bk_mem_o,
    output logic             fc_redirect_o,
    output logic [PC_W-1:0]  fc_redirect_pc_o,
    output logic [1:0]       fc_state_o,
    output logic [CNT_W-1:0] fc_stall_cnt_o,
    output logic [CNT_W-1:0] fc_flush_cnt_o
);

    fc_state_e        state_q, state_d;
    logic [PC_W-1:0]  pending_pc_q, pending_pc_d;
    logic             ic_done_q, ic_done_d;

    fc_ctl_t          ctl;
    logic [PC_W-1:0]  redirect_pc;

    logic             redir_req;
    logic [PC_W-1:0]  redir_tgt;
    logic             fetch_back;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // A branch resolved in EX is older than a jump in ID, so it wins.
    assign redir_req  = ex_btype_taken_i | id_jump_flag_i;
    assign redir_tgt  = ex_btype_taken_i ? ex_btype_jump_pc_i : id_jump_pc_i;
    // In IWAIT a redirect or Dcache stall is treated as if the fetch had not returned.
    assign fetch_back = (state_q == FC_RUN) && Icache_ready_i;

    // Next-state and control strobes, in priority Dcache > redirect > load-use > Icache.
    always_comb begin
        state_d      = state_q;
        pending_pc_d = pending_pc_q;
        ic_done_d    = ic_done_q;
        ctl          = '0;
        redirect_pc  = '0;

        unique case (state_q)
            FC_RUN, FC_IWAIT: begin
                if (Dcache_stall_i) begin
                    // Freeze everything; remember whether the fetch already came back.
                    ctl       = fc_freeze(ctl);
                    ctl.valid = fetch_back;
                    ic_done_d = fetch_back;
                    state_d   = FC_DSTALL;
                end else if (redir_req) begin
                    ctl.flush_id = 1'b1;
                    ctl.flush_ex = ex_btype_taken_i;
                    if (fetch_back) begin
                        ctl.redirect = 1'b1;
                        redirect_pc  = redir_tgt;
                    end else begin
                        // Fetch still outstanding: park the target until it returns.
                        ctl.bk_if    = 1'b1;
                        pending_pc_d = redir_tgt;
                        state_d      = FC_SQUASH;
                    end
                end else if (dhnf_load_use_i) begin
                    ctl.bk_if    = 1'b1;
                    ctl.bk_id    = 1'b1;
                    ctl.flush_ex = 1'b1;
                end else begin
                    ctl.valid = Icache_ready_i;
                    ctl.bk_if = ~Icache_ready_i;
                    state_d   = Icache_ready_i ? FC_RUN : FC_IWAIT;
                end
            end

            FC_SQUASH: begin
                // Keep ID empty until the stale fetch drains; new requests are ignored.
                ctl.bk_if    = 1'b1;
                ctl.flush_id = 1'b1;
                if (Dcache_stall_i) begin
                    ctl = fc_freeze(ctl);
                end else if (Icache_ready_i) begin
                    ctl.redirect = 1'b1;
                    redirect_pc  = pending_pc_q;
                    state_d      = FC_RUN;
                end
            end

            FC_DSTALL: begin
                // ID buffers any instruction arriving while the pipeline is frozen.
                ctl       = fc_freeze(ctl);
                ctl.valid = Icache_ready_i;
                if (Dcache_stall_i) begin
                    ic_done_d = ic_done_q | Icache_ready_i;
                end else begin
                    // A return on the release cycle is captured too, so it counts as done.
                    state_d   = (ic_done_q | Icache_ready_i) ? FC_RUN : FC_IWAIT;
                    ic_done_d = 1'b0;
                end
            end

            default: begin
                state_d = FC_RUN;
            end
        endcase
    end

    // State, pending redirect target and buffered-fetch flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FC_RUN;
            pending_pc_q <= '0;
            ic_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_pc_q <= pending_pc_d;
            ic_done_q    <= ic_done_d;
        end
    end

    // All outputs read as zero while reset is asserted.
    assign fc_Icache_data_valid_o = ~rst & ctl.valid;
    assign fc_flush_id_o          = ~rst & ctl.flush_id;
    assign fc_flush_ex_o          = ~rst & ctl.flush_ex;
    assign fc_bk_if_o             = ~rst & ctl.bk_if;
    assign fc_bk_id_o             = ~rst & ctl.bk_id;
    assign fc_bk_ex_o             = ~rst & ctl.bk_ex;
    assign fc_bk_mem_o            = ~rst & ctl.bk_mem;
    assign fc_redirect_o          = ~rst & ctl.redirect;
    assign fc_redirect_pc_o       = rst ? '0 : redirect_pc;
    assign fc_state_o             = rst ? 2'd0 : state_q;
    assign fc_stall_cnt_o         = rst ? '0 : stall_cnt;
    assign fc_flush_cnt_o         = rst ? '0 : flush_cnt;

    fc_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (fc_bk_if_o),
        .cnt_o (stall_cnt)
    );

    fc_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (fc_redirect_o),
        .cnt_o (flush_cnt)
    );

endmodule

// File: tb/tb_fc_ctrl.sv
// Self-checking bench for fc_ctrl: directed vector table, randomized run against
// a flag-based reference model, and counter saturation on a narrow instance.
module tb_fc_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (32-bit counters)
    logic        rst, rdy, dst, lu, jf, bt;
    logic [31:0] jpc, bpc;
    logic        o_valid, o_fid, o_fex, o_bkif, o_bkid, o_bkex, o_bkmem, o_redir;
    logic [31:0] o_rpc, o_sc, o_fc;
    logic [1:0]  o_st;

    fc_ctrl #(.CNT_W(32), .PC_W(32)) dut (
        .clk(clk), .rst(rst),
        .Icache_ready_i(rdy), .Dcache_stall_i(dst), .dhnf_load_use_i(lu),
        .id_jump_flag_i(jf), .id_jump_pc_i(jpc),
        .ex_btype_taken_i(bt), .ex_btype_jump_pc_i(bpc),
        .fc_Icache_data_valid_o(o_valid), .fc_flush_id_o(o_fid), .fc_flush_ex_o(o_fex),
        .fc_bk_if_o(o_bkif), .fc_bk_id_o(o_bkid), .fc_bk_ex_o(o_bkex), .fc_bk_mem_o(o_bkmem),
        .fc_redirect_o(o_redir), .fc_redirect_pc_o(o_rpc), .fc_state_o(o_st),
        .fc_stall_cnt_o(o_sc), .fc_flush_cnt_o(o_fc)
    );

    // Narrow-counter instance for saturation
    logic        s_rst, s_rdy, s_bt;
    logic        s_valid, s_fid, s_fex, s_bkif, s_bkid, s_bkex, s_bkmem, s_redir;
    logic [31:0] s_rpc;
    logic [1:0]  s_st;
    logic [3:0]  s_sc, s_fc;

    fc_ctrl #(.CNT_W(4), .PC_W(32)) dut4 (
        .clk(clk), .rst(s_rst),
        .Icache_ready_i(s_rdy), .Dcache_stall_i(1'b0), .dhnf_load_use_i(1'b0),
        .id_jump_flag_i(1'b0), .id_jump_pc_i(32'h0),
        .ex_btype_taken_i(s_bt), .ex_btype_jump_pc_i(32'h0000_0400),
        .fc_Icache_data_valid_o(s_valid), .fc_flush_id_o(s_fid), .fc_flush_ex_o(s_fex),
        .fc_bk_if_o(s_bkif), .fc_bk_id_o(s_bkid), .fc_bk_ex_o(s_bkex), .fc_bk_mem_o(s_bkmem),
        .fc_redirect_o(s_redir), .fc_redirect_pc_o(s_rpc), .fc_state_o(s_st),
        .fc_stall_cnt_o(s_sc), .fc_flush_cnt_o(s_fc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ctl bit order: {valid, flush_id, flush_ex, bk_if, bk_id, bk_ex, bk_mem, redirect}
    function automatic logic [7:0] dut_ctl();
        return {o_valid, o_fid, o_fex, o_bkif, o_bkid, o_bkex, o_bkmem, o_redir};
    endfunction

    typedef struct {
        logic        rst, rdy, dst, lu, jf;
        logic [31:0] jpc;
        logic        bt;
        logic [31:0] bpc;
        logic [7:0]  ctl;
        logic [31:0] rpc;
        logic [1:0]  st;
        logic [31:0] sc, fc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic y, input logic d, input logic l,
                                input logic j, input logic [31:0] jp, input logic b,
                                input logic [31:0] bp, input logic [7:0] c, input logic [31:0] p,
                                input logic [1:0] s, input logic [31:0] sc, input logic [31:0] fc);
        vec_t v;
        v.rst = r; v.rdy = y; v.dst = d; v.lu = l; v.jf = j; v.jpc = jp; v.bt = b; v.bpc = bp;
        v.ctl = c; v.rpc = p; v.st = s; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic drive(input logic r, input logic y, input logic d, input logic l,
                         input logic j, input logic [31:0] jp, input logic b, input logic [31:0] bp);
        rst = r; rdy = y; dst = d; lu = l; jf = j; jpc = jp; bt = b; bpc = bp;
    endtask

    // Reference model: flags describing what the front end is doing
    bit          m_wait_fetch, m_squashing, m_frozen, m_have_fetch;
    logic [31:0] m_pending;
    longint      m_scnt, m_fcnt;
    logic [7:0]  e_ctl;
    logic [31:0] e_rpc;
    logic [1:0]  e_st;
    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;

    task automatic model_reset();
        m_wait_fetch = 0; m_squashing = 0; m_frozen = 0; m_have_fetch = 0;
        m_pending = '0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic model_eval();
        logic want = bt | jf;
        logic [31:0] tgt = bt ? bpc : jpc;
        logic returned_now = !m_wait_fetch && rdy;
        e_ctl = '0; e_rpc = '0;
        if (m_frozen) begin
            e_ctl = {rdy, 2'b00, 4'b1111, 1'b0};
        end else if (m_squashing) begin
            if (dst)      e_ctl = 8'b0101_1110;
            else if (rdy) begin e_ctl = 8'b0101_0001; e_rpc = m_pending; end
            else          e_ctl = 8'b0101_0000;
        end else if (dst) begin
            e_ctl = {returned_now, 2'b00, 4'b1111, 1'b0};
        end else if (want) begin
            if (returned_now) begin e_ctl = {1'b0, 1'b1, bt, 4'b0000, 1'b1}; e_rpc = tgt; end
            else              e_ctl = {1'b0, 1'b1, bt, 4'b1000, 1'b0};
        end else if (lu) begin
            e_ctl = 8'b0011_1000;
        end else begin
            e_ctl = {rdy, 2'b00, !rdy, 4'b0000};
        end
        e_st = m_frozen ? 2'd3 : m_squashing ? 2'd2 : m_wait_fetch ? 2'd1 : 2'd0;
        if (rst) begin e_ctl = '0; e_rpc = '0; e_st = '0; end
    endtask

    task automatic model_commit();
        logic want = bt | jf;
        if (rst) begin model_reset(); return; end
        if (e_ctl[4] && m_scnt < MAX32) m_scnt++;
        if (e_ctl[0] && m_fcnt < MAX32) m_fcnt++;
        if (m_frozen) begin
            if (!dst) begin
                m_frozen = 0; m_wait_fetch = !(m_have_fetch || rdy); m_have_fetch = 0;
            end else if (rdy) m_have_fetch = 1;
        end else if (m_squashing) begin
            if (!dst && rdy) m_squashing = 0;
        end else if (dst) begin
            m_have_fetch = !m_wait_fetch && rdy; m_frozen = 1; m_wait_fetch = 0;
        end else if (want) begin
            if (!(!m_wait_fetch && rdy)) begin
                m_squashing = 1; m_wait_fetch = 0; m_pending = bt ? bpc : jpc;
            end
        end else if (!lu) begin
            m_wait_fetch = !rdy;
        end
    endtask

    initial begin
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        drive(1, 1, 1, 1, 1, ones, 1, ones);
        s_rst = 1; s_rdy = 0; s_bt = 0;

        //          rst rdy dst lu jf jpc      bt bpc      ctl           rpc      st sc fc
        tbl.push_back(mk(1, 1, 1, 1, 1, ones,   1, ones,   8'b0000_0000, 0,       0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, ones,   1, ones,   8'b0000_0000, 0,       0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, ones,   1, ones,   8'b0000_0000, 0,       0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0,      8'b1000_0000, 0,       0, 0, 0));
        // Icache miss for 4 cycles
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0,      8'b0001_0000, 0,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0,      8'b0001_0000, 0,       1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0,      8'b0001_0000, 0,       1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0,      8'b0001_0000, 0,       1, 3, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0,      8'b1000_0000, 0,       1, 4, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0,      8'b1000_0000, 0,       0, 4, 0));
        // Branch during fetch, return 3 cycles later
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,      1, 'h100,  8'b0111_0000, 0,       0, 4, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0,      8'b0101_0000, 0,       2, 5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0,      8'b0101_0000, 0,       2, 6, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0,      8'b0101_0001, 'h100,   2, 7, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0,      8'b1000_0000, 0,       0, 8, 1));
        // Dcache stall together with a taken branch, released with no fetch done
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,      1, 'h500,  8'b0001_1110, 0,       0, 8, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,      0, 0,      8'b0001_1110, 0,       3, 9, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0,      8'b0001_1110, 0,       3, 10, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0,      8'b1000_0000, 0,       1, 11, 1));
        // Jump vs branch, then jump alone
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h200,  1, 'h300,  8'b0110_0001, 'h300,   0, 11, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 'h200,  0, 0,      8'b0100_0001, 'h200,   0, 11, 2));
        // Load-use
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,      0, 0,      8'b0011_1000, 0,       0, 11, 3));
        // Dcache stall with fetch returning, release goes straight to RUN
        tbl.push_back(mk(0, 1, 1, 0, 0, 0,      0, 0,      8'b1001_1110, 0,       0, 12, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0,      8'b0001_1110, 0,       3, 13, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0,      8'b1000_0000, 0,       0, 14, 3));
        // Squash with Dcache stall priority and ignored requests
        tbl.push_back(mk(0, 0, 0, 0, 1, 'h240,  0, 0,      8'b0101_0000, 0,       0, 14, 3));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0,      1, 'h777,  8'b0101_1110, 0,       2, 15, 3));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,      1, 'h999,  8'b0101_0001, 'h240,   2, 16, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0,      8'b1000_0000, 0,       0, 17, 4));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].dst, tbl[i].lu, tbl[i].jf, tbl[i].jpc,
                  tbl[i].bt, tbl[i].bpc);
            #1;
            check($sformatf("row%0d ctl", i),   64'(dut_ctl()), 64'(tbl[i].ctl));
            check($sformatf("row%0d rpc", i),   64'(o_rpc),     64'(tbl[i].rpc));
            check($sformatf("row%0d state", i), 64'(o_st),      64'(tbl[i].st));
            check($sformatf("row%0d stall", i), 64'(o_sc),      64'(tbl[i].sc));
            check($sformatf("row%0d flush", i), 64'(o_fc),      64'(tbl[i].fc));
        end

        // Randomized run against the reference model, starting from reset
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), $urandom,
                  ($urandom_range(0, 7) == 0), $urandom);
            #1;
            model_eval();
            check($sformatf("rnd%0d ctl", c),   64'(dut_ctl()), 64'(e_ctl));
            check($sformatf("rnd%0d rpc", c),   64'(o_rpc),     64'(e_rpc));
            check($sformatf("rnd%0d state", c), 64'(o_st),      64'(e_st));
            check($sformatf("rnd%0d stall", c), 64'(o_sc),      64'(rst ? 0 : m_scnt));
            check($sformatf("rnd%0d flush", c), 64'(o_fc),      64'(rst ? 0 : m_fcnt));
            model_commit();
        end

        // Stall counter saturation on the 4-bit instance
        @(negedge clk);
        s_rst = 1; s_rdy = 0; s_bt = 0;
        @(negedge clk);
        s_rst = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            check($sformatf("sat_stall%0d", k), 64'(s_sc), 64'((k < 15) ? k : 15));
            @(negedge clk);
        end

        // Flush counter saturation: a taken branch with the fetch back every cycle
        s_rst = 1;
        @(negedge clk);
        s_rst = 0; s_rdy = 1; s_bt = 1;
        for (int k = 0; k < 20; k++) begin
            #1;
            check($sformatf("sat_flush%0d", k), 64'(s_fc), 64'((k < 15) ? k : 15));
            check($sformatf("sat_flush_stall%0d", k), 64'(s_sc), 64'(0));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fc_ctrl.md
Name: fc_ctrl

Overview:
Pipeline flow controller that sequences the fetch/decode front end around the ID stage.
- Arbitrates stall and flush causes: Dcache stall, EX branch taken, ID jump, load-use hazard and Icache latency.
- Drives per-stage keep (bk) and flush signals, the Icache data-valid qualifier into ID, and the PC redirect to IF.
- Squashes an in-flight Icache fetch when a redirect arrives before that fetch returns.
- Keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 32, width of performance counters
PC_W, 32, width of redirect PC

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
Icache_ready_i  in  1  Icache returns an instruction this cycle
Dcache_stall_i  in  1  Dcache miss in MEM; whole pipeline must hold
dhnf_load_use_i  in  1  load-use hazard detected for the instruction in ID
id_jump_flag_i  in  1  jal/jalr decoded in ID
id_jump_pc_i  in  PC_W  jal/jalr target
ex_btype_taken_i  in  1  branch resolved taken in EX
ex_btype_jump_pc_i  in  PC_W  branch target
fc_Icache_data_valid_o  out  1  Icache data is valid for ID
fc_flush_id_o  out  1  insert bubble into ID next cycle
fc_flush_ex_o  out  1  insert bubble into EX next cycle
fc_bk_if_o  out  1  hold PC/IF
fc_bk_id_o  out  1  hold ID (ID buffers Icache data)
fc_bk_ex_o  out  1  hold EX
fc_bk_mem_o  out  1  hold MEM
fc_redirect_o  out  1  load PC with fc_redirect_pc_o (1-cycle pulse)
fc_redirect_pc_o  out  PC_W  redirect target
fc_state_o  out  2  current state (debug)
fc_stall_cnt_o  out  CNT_W  cycles stalled, saturating
fc_flush_cnt_o  out  CNT_W  redirects issued, saturating

Behaviour:
- States: RUN=0, IWAIT=1, SQUASH=2, DSTALL=3. All control outputs are combinational from state, inputs and registers, with zero-cycle latency.
- Redirect request: ex_btype_taken_i has priority over id_jump_flag_i. Target is ex_btype_jump_pc_i, else id_jump_pc_i.
- Flushes on a redirect request: an EX-sourced request asserts flush_id and flush_ex. An ID-sourced request asserts flush_id only.
- Global priority: Dcache_stall_i > redirect > dhnf_load_use_i > Icache wait.
- Reset: while rst=1 all outputs are forced to 0. On the cycle after reset: state=RUN, pending_pc=0, both counters=0.
- RUN, with Dcache_stall_i=1:
  - bk_if/id/ex/mem=1 in the same cycle; go to DSTALL.
  - ic_done is set to Icache_ready_i.
- RUN, with a redirect request:
  - If Icache_ready_i=1: redirect_o=1 with the target, flushes as above, valid_o=0; stay RUN.
  - If Icache_ready_i=0: latch target into pending_pc, assert flushes, redirect_o=0; go to SQUASH.
- RUN, with load-use (no redirect): bk_if=bk_id=1, flush_ex=1, valid_o=0; stay RUN.
- RUN, otherwise: valid_o=Icache_ready_i. If Icache_ready_i=0, then bk_if=1 and go to IWAIT.
- IWAIT:
  - bk_if=1, valid_o=0.
  - On Icache_ready_i=1: valid_o=1, bk_if=0; go to RUN.
  - A redirect or Dcache stall is handled exactly as in RUN with Icache_ready_i=0: go to SQUASH, or to DSTALL with ic_done=0.
- SQUASH:
  - valid_o=0, bk_if=1, flush_id=1 every cycle. Further redirect or load-use requests are ignored.
  - On Icache_ready_i=1: the returned data is discarded, redirect_o=1 with pending_pc; go to RUN.
  - Dcache_stall_i has priority: stay in SQUASH and add all bk signals.
- DSTALL:
  - All bk=1. valid_o=Icache_ready_i, so ID captures the instruction into its buffer.
  - ic_done is set on any Icache_ready_i. Redirect and load-use inputs are ignored, since the pipeline is frozen and they are re-presented afterwards.
  - On Dcache_stall_i=0: if ic_done=1 go to RUN, else go to IWAIT. Clear ic_done.
- Counters:
  - fc_stall_cnt_o increments on any cycle where fc_bk_if_o=1.
  - fc_flush_cnt_o increments on each redirect_o pulse.
  - Both saturate at all-ones and never wrap.

Decomposition:
- State encodings FC_RUN/FC_IWAIT/FC_SQUASH/FC_DSTALL are added to define.v.
- One sub-module, fc_sat_cnt (enable, width-parameterized, saturating), is instantiated twice.
- Next-state and output logic stay in fc_ctrl.

Test Plan:
- Reset: rst=1 for 3 cycles with all inputs at 1 -> all outputs 0. After release: state=0, counters=0.
- Icache miss: Icache_ready_i=0 for 4 cycles, then 1 -> state goes 1,1,1,1,0. valid_o=1 only on the return cycle. stall_cnt=4.
- Branch during fetch: in RUN with Icache_ready_i=0, ex_btype_taken_i=1 and pc=0x100 -> flush_id=flush_ex=1, state=2. Ready arrives 3 cycles later -> valid_o=0, redirect_o=1 with pc 0x100, flush_cnt=1.
- Simultaneous events: Dcache_stall_i=1 together with ex_btype_taken_i=1 -> all bk=1, redirect_o=0, state=3. Stall drops with ic_done=0 -> state=1.
- Jump vs branch: id_jump_flag_i=1 (pc 0x200) together with ex_btype_taken_i=1 (pc 0x300), Icache_ready_i=1 -> redirect to 0x300, flush_ex=1.
- Saturation: preload near max (CNT_W=4) and run 20 stall cycles -> fc_stall_cnt_o stays at 0xF.
